ins_fetch_ctrl: RTL and testbench
=================================

Name: ins_fetch_ctrl

Overview:
- Sequences instruction fetch from the byte-wide instruction memory (8-bit words, big-endian, combinational read).
- Owns the PC and reads four consecutive bytes per instruction. Assembles them as {B[pc], B[pc+1], B[pc+2], B[pc+3]}.
- Presents the 32-bit word to decode with a valid/ready handshake.
- Accepts branch/jump redirects from the datapath. Stops on a halt opcode or an out-of-range fetch.

Parameters:
- PC_RESET, 32'h0000_0000: PC loaded on reset.
- MEM_BYTES, 128: instruction memory size in bytes; used for the range check.
- HALT_OP, 6'b111111: opcode (ins[31:26]) that halts fetch once accepted.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- mem_addr  out  32  byte address to instruction memory.
- mem_rd  out  1  read strobe; 1 in FETCH state only.
- mem_rdata  in  8  byte returned combinationally for mem_addr.
- ins  out  32  assembled instruction.
- ins_pc  out  32  PC of ins.
- ins_valid  out  1  ins/ins_pc valid.
- ins_ready  in  1  decode accepts ins.
- redirect  in  1  single-cycle request to change PC.
- redirect_pc  in  32  redirect target.
- pc  out  32  current fetch PC.
- halt  out  1  fetch stopped (sticky until Reset).
- addr_err  out  1  sticky; misaligned redirect or out-of-range fetch.

Behaviour:
- Reset values:
  - state=IDLE, pc=PC_RESET, byte index idx=0.
  - ins=0, ins_pc=0, ins_valid=0, mem_rd=0, mem_addr=PC_RESET, halt=0, addr_err=0.
  - Reset mid-fetch discards all partial bytes.
- States: IDLE, FETCH, VALID, HALTED.
- IDLE: one cycle, then go to FETCH with idx=0.
- FETCH:
  - mem_rd=1, mem_addr=pc+idx (32-bit wrap).
  - Each edge latches mem_rdata into ins byte lane (3-idx) and increments idx.
  - After the idx=3 edge: state goes to VALID, ins_pc=pc, idx=0.
  - Range check on entering FETCH with idx=0: if pc > MEM_BYTES-4, go to HALTED with addr_err=1 and halt=1, and issue no read.
- Latency: ins_valid rises 4 edges after FETCH is entered, and 5 edges after Reset deasserts.
- VALID:
  - ins_valid=1; ins and ins_pc are held stable while ins_ready=0.
  - On ins_valid&ins_ready: if ins[31:26]==HALT_OP, go to HALTED with halt=1. Otherwise pc<=pc+4 and go to FETCH.
- Redirect, in IDLE/FETCH/VALID:
  - pc<={redirect_pc[31:2],2'b00}, idx=0, next state FETCH. Any partial word is discarded.
  - In VALID, ins_valid drops on the next edge.
  - If redirect_pc[1:0]!=0, set addr_err=1 (sticky); fetch continues at the aligned address.
- Simultaneous redirect and handshake in VALID: the instruction counts as accepted; redirect_pc sets the next PC; a HALT_OP is still honoured (HALTED wins).
- HALTED: mem_rd=0, ins_valid=0. redirect and ins_ready are ignored. Only Reset exits.
- PC arithmetic is 32-bit unsigned modulo 2^32. No carry or overflow flag.

Decomposition:
- Shared package cpu_pkg:
  - State encoding (IDLE/FETCH/VALID/HALTED).
  - Opcode constants, including HALT_OP.
  - Instruction field bit positions (opCode 31:26, rs 25:21, rt 20:16, rd 15:11, sa 10:6, imm 15:0, j_addr 25:0).
- One sub-module, ins_byte_packer: holds the 2-bit idx counter and 32-bit shift/assembly register, with clear and load-enable inputs.
- The FSM, PC and range check stay in ins_fetch_ctrl.

Test Plan:
- Memory bytes 0..3 = 20 01 00 05, ins_ready=1 -> after Reset release, ins_valid at edge 5 with ins=32'h20010005 and ins_pc=0; mem_addr steps 0,1,2,3, then 4.
- Backpressure: ins_ready=0 for 6 cycles in VALID -> ins and ins_pc stable; no mem_rd; pc unchanged. With ready=1 -> next fetch at pc=4.
- Redirect mid-fetch at idx=2 with redirect_pc=0x10 -> partial word dropped; next mem_addr=0x10; ins_pc=0x10 when valid.
- Redirect with redirect_pc=0x13 -> addr_err=1; fetch from 0x10. Redirect coincident with handshake -> accepted word not repeated; next ins_pc=target.
- Word at 8 = FC000000 (HALT_OP) -> after accept, halt=1 and mem_rd=0; later redirect is ignored; Reset clears halt.
- Redirect to 0x7C with MEM_BYTES=128 -> fetch succeeds. Accept -> pc=0x80 out of range -> addr_err=1, halt=1, no read issued.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, opcode constants and
// instruction field positions used by the fetch front end and decode.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_VALID  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    // Opcodes (ins[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_HALT    = 6'b111111;

    // Instruction field bit positions
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SA_HI     = 10;
    localparam int SA_LO     = 6;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;
    localparam int JADDR_HI  = 25;
    localparam int JADDR_LO  = 0;

    function automatic logic [5:0] opcode_of(input logic [31:0] ins);
        return ins[OPCODE_HI:OPCODE_LO];
    endfunction

endpackage

// File: rtl/ins_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, the byte-wide instruction memory,
// decode and the datapath redirect path.
//
// Handshake: ins/ins_pc are offered while ins_valid=1 and stay stable until
// the edge where ins_valid & ins_ready are both 1; that edge transfers the
// word. ins_valid never waits on ins_ready. redirect is a single-cycle strobe
// sampled on the edge, with no acknowledge.
interface ins_fetch_ctrl_if;
    import cpu_pkg::*;

    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic        halt;
    logic        addr_err;

    modport master (
        output mem_addr, mem_rd, ins, ins_pc, ins_valid, pc, halt, addr_err,
        input  mem_rdata, ins_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_addr, mem_rd, ins, ins_pc, ins_valid, pc, halt, addr_err,
        output mem_rdata, ins_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/ins_byte_packer.sv
// Assembles four big-endian bytes into a 32-bit word. idx selects the byte
// lane (3-idx) written on each load; clear drops any partial word.
module ins_byte_packer
    import cpu_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset,
    input  logic        clr,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [1:0]  idx,
    output logic [31:0] word
);

    // Byte index counter and assembly register; clear wins over load.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            idx  <= 2'd0;
            word <= 32'd0;
        end else if (clr) begin
            idx  <= 2'd0;
            word <= 32'd0;
        end else if (load) begin
            // lane 3-idx starts at bit 8*(3-idx); for a 2-bit idx 3-idx == ~idx
            word[{~idx, 3'b000} +: 8] <= byte_in;
            idx                       <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/ins_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads four bytes per instruction,
// offers the word to decode, follows redirects and stops on HALT or on a
// fetch past the end of instruction memory.
module ins_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 128,
    parameter logic [5:0]  HALT_OP   = OP_HALT
)(
    input  logic               CLK,
    input  logic               Reset,
    ins_fetch_ctrl_if.master   bus,
    output fetch_state_t       dbg_state
);

    // Highest PC whose four bytes all lie inside the memory.
    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    fetch_state_t state, state_n;
    logic [31:0]  pc_q, pc_n, ins_pc_q;
    logic         addr_err_q, err_set;
    logic         pk_clr, pk_load, capture;
    logic [1:0]   idx;
    logic [31:0]  word;
    logic [31:0]  redirect_target;
    logic         misaligned, out_of_range, start_blocked, accept, is_halt;

    ins_byte_packer u_packer (
        .CLK     (CLK),
        .Reset   (Reset),
        .clr     (pk_clr),
        .load    (pk_load),
        .byte_in (bus.mem_rdata),
        .idx     (idx),
        .word    (word)
    );

    assign redirect_target = {bus.redirect_pc[31:2], 2'b00};
    assign misaligned      = bus.redirect & (bus.redirect_pc[1:0] != 2'b00);
    assign out_of_range    = (pc_q > LAST_WORD);
    // A word that would start past the end is refused before any byte read.
    assign start_blocked   = (idx == 2'd0) && out_of_range;
    assign accept          = (state == ST_VALID) && bus.ins_ready;
    assign is_halt         = (opcode_of(word) == HALT_OP);

    // Next-state, next-PC and packer control.
    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        pk_clr  = 1'b0;
        pk_load = 1'b0;
        capture = 1'b0;
        err_set = 1'b0;
        case (state)
            ST_IDLE: begin
                state_n = ST_FETCH;
                pk_clr  = 1'b1;
                if (bus.redirect) begin
                    pc_n    = redirect_target;
                    err_set = misaligned;
                end
            end
            ST_FETCH: begin
                if (bus.redirect) begin
                    pc_n    = redirect_target;
                    pk_clr  = 1'b1;
                    err_set = misaligned;
                end else if (start_blocked) begin
                    state_n = ST_HALTED;
                    err_set = 1'b1;
                end else begin
                    pk_load = 1'b1;
                    if (idx == 2'd3) begin
                        capture = 1'b1;
                        state_n = ST_VALID;
                    end
                end
            end
            ST_VALID: begin
                // An accepted HALT stops fetch even if a redirect coincides.
                if (accept && is_halt) begin
                    state_n = ST_HALTED;
                    err_set = misaligned;
                end else if (bus.redirect) begin
                    pc_n    = redirect_target;
                    pk_clr  = 1'b1;
                    state_n = ST_FETCH;
                    err_set = misaligned;
                end else if (accept) begin
                    pc_n    = pc_q + 32'd4;
                    pk_clr  = 1'b1;
                    state_n = ST_FETCH;
                end
            end
            ST_HALTED: begin
                state_n = ST_HALTED;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, PC, captured ins_pc and sticky address error registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            pc_q       <= PC_RESET;
            ins_pc_q   <= 32'd0;
            addr_err_q <= 1'b0;
        end else begin
            state <= state_n;
            pc_q  <= pc_n;
            if (capture) begin
                ins_pc_q <= pc_q;
            end
            if (err_set) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    assign bus.mem_addr  = pc_q + {30'd0, idx};
    assign bus.mem_rd    = (state == ST_FETCH) && !start_blocked;
    assign bus.ins       = word;
    assign bus.ins_pc    = ins_pc_q;
    assign bus.ins_valid = (state == ST_VALID);
    assign bus.pc        = pc_q;
    assign bus.halt      = (state == ST_HALTED);
    assign bus.addr_err  = addr_err_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Bench for ins_fetch_ctrl: byte memory model, directed scenarios and a
// randomized instruction stream checked against a PC/word reference model.
module tb_ins_fetch_ctrl;
    import cpu_pkg::*;

    localparam int MEM_BYTES = 128;

    logic         CLK = 1'b0;
    logic         Reset = 1'b1;
    fetch_state_t dbg_state;
    logic [7:0]   mem [0:MEM_BYTES-1];
    int           n_checks = 0;
    int           n_pass = 0;
    logic [31:0]  exp_q[$];

    ins_fetch_ctrl_if bus();

    ins_fetch_ctrl #(
        .PC_RESET  (32'h0000_0000),
        .MEM_BYTES (MEM_BYTES),
        .HALT_OP   (6'b111111)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / memory ----------------
    always #5 CLK = ~CLK;

    assign bus.mem_rdata = (bus.mem_addr < 32'(MEM_BYTES)) ? mem[bus.mem_addr[6:0]] : 8'h00;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [6:0] b;
        b = a[6:0];
        return {mem[b], mem[b + 7'd1], mem[b + 7'd2], mem[b + 7'd3]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic fill_mem();
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom_range(0, 255));
        // keep random words from carrying the halt opcode
        for (int i = 0; i < MEM_BYTES; i += 4)
            if (mem[i][7:2] == 6'h3F) mem[i][7] = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Leaves Reset released 1 time unit after an edge; the next edge is edge 1.
    task automatic do_reset(input logic rdy);
        Reset = 1'b1;
        bus.ins_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
        bus.ins_ready = rdy;
    endtask

    task automatic wait_valid(input int max_cycles, output int cycles);
        cycles = 0;
        while (bus.ins_valid !== 1'b1 && cycles < max_cycles) begin
            tick();
            cycles++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int cyc;
        fill_mem();
        do_reset(1'b0);
        Reset = 1'b1;
        #1;
        n_checks++; if ({bus.ins, bus.ins_pc, bus.ins_valid, bus.mem_rd} !== {32'd0, 32'd0, 1'b0, 1'b0})
            $display("FAIL reset_outputs: got ins=%h ins_pc=%h valid=%b rd=%b want 0", bus.ins, bus.ins_pc, bus.ins_valid, bus.mem_rd);
        else n_pass++;
        n_checks++; if ({bus.mem_addr, bus.pc, bus.halt, bus.addr_err} !== {32'd0, 32'd0, 1'b0, 1'b0})
            $display("FAIL reset_pc: got mem_addr=%h pc=%h halt=%b err=%b want 0", bus.mem_addr, bus.pc, bus.halt, bus.addr_err);
        else n_pass++;
        // reset landing in the middle of a fetch
        do_reset(1'b0);
        repeat (3) tick();
        #2 Reset = 1'b1;
        #1;
        n_checks++; if ({bus.ins, bus.mem_rd, bus.mem_addr} !== {32'd0, 1'b0, 32'd0})
            $display("FAIL reset_mid_fetch: got ins=%h rd=%b addr=%h want 0/0/0", bus.ins, bus.mem_rd, bus.mem_addr);
        else n_pass++;
        do_reset(1'b0);
        wait_valid(10, cyc);
        n_checks++; if (cyc !== 5)
            $display("FAIL reset_latency: got valid after %0d edges want 5", cyc);
        else n_pass++;
        n_checks++; if (bus.ins !== word_at(32'd0))
            $display("FAIL reset_refetch: got %h want %h", bus.ins, word_at(32'd0));
        else n_pass++;
    endtask

    task automatic test_first_fetch();
        logic [31:0] want;
        fill_mem();
        mem[0] = 8'h20; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h05;
        do_reset(1'b1);
        exp_q = {32'd0, 32'd1, 32'd2, 32'd3};
        for (int e = 1; e <= 4; e++) begin
            tick();
            want = exp_q.pop_front();
            n_checks++; if ({bus.mem_addr, bus.mem_rd, bus.ins_valid} !== {want, 1'b1, 1'b0})
                $display("FAIL first_addr: edge %0d got addr=%h rd=%b valid=%b want %h/1/0", e, bus.mem_addr, bus.mem_rd, bus.ins_valid, want);
            else n_pass++;
        end
        tick();
        n_checks++; if ({bus.ins_valid, bus.ins, bus.ins_pc} !== {1'b1, 32'h20010005, 32'd0})
            $display("FAIL first_word: got valid=%b ins=%h pc=%h want 1/20010005/0", bus.ins_valid, bus.ins, bus.ins_pc);
        else n_pass++;
        tick();
        n_checks++; if ({bus.mem_addr, bus.pc, bus.ins_valid} !== {32'd4, 32'd4, 1'b0})
            $display("FAIL first_next: got addr=%h pc=%h valid=%b want 4/4/0", bus.mem_addr, bus.pc, bus.ins_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int cyc;
        fill_mem();
        do_reset(1'b0);
        wait_valid(10, cyc);
        n_checks++; if (bus.ins_valid !== 1'b1)
            $display("FAIL bp_timeout: got valid=%b want 1", bus.ins_valid);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if ({bus.ins_valid, bus.ins, bus.ins_pc, bus.mem_rd, bus.pc} !== {1'b1, word_at(32'd0), 32'd0, 1'b0, 32'd0})
                $display("FAIL bp_hold: got valid=%b ins=%h ins_pc=%h rd=%b pc=%h want 1/%h/0/0/0",
                         bus.ins_valid, bus.ins, bus.ins_pc, bus.mem_rd, bus.pc, word_at(32'd0));
            else n_pass++;
        end
        bus.ins_ready = 1'b1;
        tick();
        bus.ins_ready = 1'b0;
        n_checks++; if ({bus.pc, bus.mem_addr, bus.mem_rd, bus.ins_valid} !== {32'd4, 32'd4, 1'b1, 1'b0})
            $display("FAIL bp_release: got pc=%h addr=%h rd=%b valid=%b want 4/4/1/0", bus.pc, bus.mem_addr, bus.mem_rd, bus.ins_valid);
        else n_pass++;
        wait_valid(10, cyc);
        n_checks++; if ({bus.ins_valid, bus.ins_pc, bus.ins} !== {1'b1, 32'd4, word_at(32'd4)})
            $display("FAIL bp_second: got valid=%b pc=%h ins=%h want 1/4/%h", bus.ins_valid, bus.ins_pc, bus.ins, word_at(32'd4));
        else n_pass++;
    endtask

    task automatic test_redirect_mid_fetch();
        int cyc;
        fill_mem();
        do_reset(1'b0);
        repeat (3) tick();
        n_checks++; if (bus.mem_addr !== 32'd2)
            $display("FAIL rmf_idx2: got addr=%h want 2", bus.mem_addr);
        else n_pass++;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h10;
        tick();
        bus.redirect = 1'b0;
        n_checks++; if ({bus.mem_addr, bus.ins_valid, bus.addr_err} !== {32'h10, 1'b0, 1'b0})
            $display("FAIL rmf_target: got addr=%h valid=%b err=%b want 10/0/0", bus.mem_addr, bus.ins_valid, bus.addr_err);
        else n_pass++;
        wait_valid(10, cyc);
        n_checks++; if ({bus.ins_valid, bus.ins_pc, bus.ins} !== {1'b1, 32'h10, word_at(32'h10)})
            $display("FAIL rmf_word: got valid=%b pc=%h ins=%h want 1/10/%h", bus.ins_valid, bus.ins_pc, bus.ins, word_at(32'h10));
        else n_pass++;
    endtask

    task automatic test_misaligned_coincident();
        int cyc;
        fill_mem();
        do_reset(1'b0);
        wait_valid(10, cyc);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h13;
        tick();
        bus.redirect = 1'b0;
        n_checks++; if ({bus.addr_err, bus.mem_addr, bus.ins_valid} !== {1'b1, 32'h10, 1'b0})
            $display("FAIL mis_redirect: got err=%b addr=%h valid=%b want 1/10/0", bus.addr_err, bus.mem_addr, bus.ins_valid);
        else n_pass++;
        wait_valid(10, cyc);
        n_checks++; if ({bus.ins_pc, bus.ins} !== {32'h10, word_at(32'h10)})
            $display("FAIL mis_word: got pc=%h ins=%h want 10/%h", bus.ins_pc, bus.ins, word_at(32'h10));
        else n_pass++;
        bus.ins_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h40;
        tick();
        bus.ins_ready = 1'b0;
        bus.redirect = 1'b0;
        n_checks++; if ({bus.ins_valid, bus.pc, bus.addr_err} !== {1'b0, 32'h40, 1'b1})
            $display("FAIL coinc_accept: got valid=%b pc=%h err=%b want 0/40/1", bus.ins_valid, bus.pc, bus.addr_err);
        else n_pass++;
        wait_valid(10, cyc);
        n_checks++; if ({bus.ins_valid, bus.ins_pc, bus.ins} !== {1'b1, 32'h40, word_at(32'h40)})
            $display("FAIL coinc_next: got valid=%b pc=%h ins=%h want 1/40/%h", bus.ins_valid, bus.ins_pc, bus.ins, word_at(32'h40));
        else n_pass++;
    endtask

    task automatic test_halt();
        int cyc;
        fill_mem();
        mem[8] = 8'hFC; mem[9] = 8'h00; mem[10] = 8'h00; mem[11] = 8'h00;
        do_reset(1'b1);
        cyc = 0;
        while (!(bus.ins_valid === 1'b1 && bus.ins_pc === 32'd8) && cyc < 30) begin
            tick();
            cyc++;
        end
        n_checks++; if ({bus.ins_valid, bus.ins} !== {1'b1, 32'hFC000000})
            $display("FAIL halt_word: got valid=%b ins=%h want 1/fc000000", bus.ins_valid, bus.ins);
        else n_pass++;
        tick();
        n_checks++; if ({bus.halt, bus.mem_rd, bus.ins_valid} !== {1'b1, 1'b0, 1'b0})
            $display("FAIL halt_enter: got halt=%b rd=%b valid=%b want 1/0/0", bus.halt, bus.mem_rd, bus.ins_valid);
        else n_pass++;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h20;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if ({bus.halt, bus.mem_rd, bus.ins_valid, bus.pc} !== {1'b1, 1'b0, 1'b0, 32'd8})
                $display("FAIL halt_ignore: got halt=%b rd=%b valid=%b pc=%h want 1/0/0/8", bus.halt, bus.mem_rd, bus.ins_valid, bus.pc);
            else n_pass++;
        end
        bus.redirect = 1'b0;
        do_reset(1'b0);
        n_checks++; if ({bus.halt, bus.addr_err, bus.pc} !== {1'b0, 1'b0, 32'd0})
            $display("FAIL halt_reset: got halt=%b err=%b pc=%h want 0/0/0", bus.halt, bus.addr_err, bus.pc);
        else n_pass++;
    endtask

    task automatic test_range_end();
        int cyc;
        fill_mem();
        do_reset(1'b1);
        tick();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h7C;
        tick();
        bus.redirect = 1'b0;
        n_checks++; if ({bus.mem_addr, bus.mem_rd} !== {32'h7C, 1'b1})
            $display("FAIL range_start: got addr=%h rd=%b want 7c/1", bus.mem_addr, bus.mem_rd);
        else n_pass++;
        wait_valid(10, cyc);
        n_checks++; if ({bus.ins_valid, bus.ins_pc, bus.ins, bus.addr_err} !== {1'b1, 32'h7C, word_at(32'h7C), 1'b0})
            $display("FAIL range_last: got valid=%b pc=%h ins=%h err=%b want 1/7c/%h/0", bus.ins_valid, bus.ins_pc, bus.ins, bus.addr_err, word_at(32'h7C));
        else n_pass++;
        tick();
        n_checks++; if ({bus.pc, bus.mem_rd, bus.halt} !== {32'h80, 1'b0, 1'b0})
            $display("FAIL range_noread: got pc=%h rd=%b halt=%b want 80/0/0", bus.pc, bus.mem_rd, bus.halt);
        else n_pass++;
        tick();
        n_checks++; if ({bus.halt, bus.addr_err, bus.mem_rd, bus.ins_valid} !== {1'b1, 1'b1, 1'b0, 1'b0})
            $display("FAIL range_halt: got halt=%b err=%b rd=%b valid=%b want 1/1/0/0", bus.halt, bus.addr_err, bus.mem_rd, bus.ins_valid);
        else n_pass++;
    endtask

    task automatic test_random_stream();
        logic [31:0] exp_pc, target;
        logic        rdy, rd;
        int          accepted, idle;
        fill_mem();
        do_reset(1'b0);
        exp_pc = 32'd0;
        accepted = 0;
        idle = 0;
        for (int cyc = 0; cyc < 800 && accepted < 60; cyc++) begin
            tick();
            if (bus.ins_valid === 1'b1) begin
                idle = 0;
                n_checks++; if ({bus.ins_pc, bus.ins, bus.mem_rd} !== {exp_pc, word_at(exp_pc), 1'b0})
                    $display("FAIL stream_word: got pc=%h ins=%h rd=%b want %h/%h/0", bus.ins_pc, bus.ins, bus.mem_rd, exp_pc, word_at(exp_pc));
                else n_pass++;
            end else begin
                idle++;
            end
            if (idle > 8) begin
                n_checks++;
                $display("FAIL stream_timeout: got no valid for %0d cycles want <=8", idle);
                break;
            end
            rdy = ($urandom_range(0, 2) != 0);
            rd  = ($urandom_range(0, 9) == 0) || (exp_pc >= 32'h70);
            target = 32'($urandom_range(0, 27)) * 32'd4;
            if (bus.ins_valid === 1'b1 && rdy) accepted++;
            if (rd) begin
                exp_pc = target;
                idle = 0;
            end else if (bus.ins_valid === 1'b1 && rdy) begin
                exp_pc = exp_pc + 32'd4;
            end
            bus.ins_ready = rdy;
            bus.redirect = rd;
            bus.redirect_pc = target;
        end
        bus.ins_ready = 1'b0;
        bus.redirect = 1'b0;
        n_checks++; if ({bus.halt, bus.addr_err} !== 2'b00 || accepted < 60)
            $display("FAIL stream_end: got halt=%b err=%b accepted=%0d want 0/0/60", bus.halt, bus.addr_err, accepted);
        else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.ins_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'd0;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect_mid_fetch();
        test_misaligned_coincident();
        test_halt();
        test_range_end();
        test_random_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
